ysyx_22050039_ctrl: RTL and testbench
=====================================

YSYX_22050039_CTRL -- requirements
Module: ysyx_22050039_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum FETCH cycles without if_ack.
REQ-002 SHALL have parameter CNT_W, default 64: width of the retired-instruction counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port if_req, output, 1 bit: instruction fetch request.
REQ-006 SHALL have port if_ack, input, 1 bit: instruction valid; qualifies the fetch.
REQ-007 SHALL have port func, input, 3 bits: decoder class. 0 addi, 1 jalr, 2 auipc, 3 lui, 4 sd, 5 jal, 6 ebreak, 7 invalid.
REQ-008 SHALL have port ex_en, output, 1 bit: execute-stage operand/result capture strobe.
REQ-009 SHALL have port mem_req, output, 1 bit: data-memory request.
REQ-010 SHALL have port mem_we, output, 1 bit: data-memory write enable.
REQ-011 SHALL have port mem_ack, input, 1 bit: data-memory completion.
REQ-012 SHALL have port reg_wen, output, 1 bit: GPR write-port enable (global gate for the rd decoder).
REQ-013 SHALL have port pc_wen, output, 1 bit: PC update enable.
REQ-014 SHALL have port halt, output, 1 bit: sticky ebreak halt.
REQ-015 SHALL have port err, output, 1 bit: sticky invalid-instruction or fetch-timeout error.
REQ-016 SHALL have port state, output, 3 bits: current FSM state encoding, for debug.
REQ-017 SHALL have port inst_cnt, output, CNT_W bits: retired-instruction count.

Function
REQ-018 SHALL implement the Moore FSM states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
REQ-019 SHALL transition IDLE -> FETCH unconditionally on the first clock after reset release.
REQ-020 In FETCH, SHALL hold if_req=1 until if_ack=1, then go to DECODE; SHALL latch func into func_q on the DECODE entry cycle.
REQ-021 SHALL count FETCH cycles without if_ack; on reaching TIMEOUT it SHALL go to ERR. If if_ack and expiry coincide, the ack wins. The counter SHALL clear on each FETCH entry.
REQ-022 In DECODE: func_q=6 -> HALT; func_q=7 -> ERR; otherwise -> EXEC.
REQ-023 In EXEC, SHALL assert ex_en=1 for exactly one cycle; then func_q=4 -> MEM, otherwise -> WB.
REQ-024 In MEM, SHALL hold mem_req=1 and mem_we=1 until mem_ack=1, then go to WB; there is no timeout in MEM.
REQ-025 In WB, for one cycle: pc_wen=1; reg_wen=1 only for func_q in {0,1,2,3,5}; inst_cnt increments by 1, wrapping modulo 2^CNT_W; next state FETCH.
REQ-026 HALT and ERR SHALL be absorbing; only reset exits them. halt=1 only in HALT; err=1 only in ERR.
REQ-027 SHALL ignore if_ack outside FETCH and mem_ack outside MEM.
REQ-028 All outputs SHALL decode from state and func_q only; no combinational path from inputs to outputs.
REQ-029 Latency: a non-store instruction with if_ack on the first FETCH cycle SHALL take 4 cycles (FETCH..WB); a store with immediate mem_ack SHALL take 5.

Reset
REQ-030 On rst=0, SHALL asynchronously set state=IDLE, func_q=0, timeout counter=0, and inst_cnt=0; all 1-bit outputs SHALL be 0.
REQ-031 Reset asserted mid-MEM or mid-FETCH SHALL drop mem_req/if_req in the same cycle without waiting for an ack.

Structure
REQ-032 The state encodings, func codes (0..7), and the TIMEOUT default SHALL live in shared package ysyx_22050039_pkg, which IDU also uses for its func encoding.
REQ-033 The design SHALL be a single FSM module with one natural sub-module, ysyx_22050039_Cnt: a wrapping counter with enable and clear, instantiated for both the timeout counter and inst_cnt.

Verification
REQ-034 addi sequence: reset, if_ack=1 every FETCH, func=0 -> state 1,2,3,5 repeating; reg_wen=pc_wen=1 in each WB; inst_cnt=3 after 12 cycles.
REQ-035 sd: func=4, mem_ack delayed 3 cycles -> mem_req=mem_we=1 for exactly 4 cycles; then WB with reg_wen=0, pc_wen=1.
REQ-036 ebreak: func=6 -> halt=1 from the cycle after DECODE; if_req stays 0 for 100 further cycles despite if_ack toggling.
REQ-037 Fetch timeout: TIMEOUT=4, if_ack=0 -> err=1 after 4 FETCH cycles. A second run with if_ack=1 on the 4th cycle -> DECODE, err=0.
REQ-038 Reset mid-MEM: rst=0 asserted while mem_req=1 -> mem_req=0 and state=0 before the next clock edge; inst_cnt=0.
REQ-039 Wrap: CNT_W=4, run 16 retired jal (func=5) -> inst_cnt returns to 0 with no error.

Source files
------------

// File: rtl/ysyx_22050039_pkg.sv
// ============================================================================
// ysyx_22050039_pkg : shared FSM state and decoder-class encodings (ctrl, IDU)
// Revision: 1.0
// ============================================================================
`default_nettype none

package ysyx_22050039_pkg;

  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    F_ADDI    = 3'd0,
    F_JALR    = 3'd1,
    F_AUIPC   = 3'd2,
    F_LUI     = 3'd3,
    F_SD      = 3'd4,
    F_JAL     = 3'd5,
    F_EBREAK  = 3'd6,
    F_INVALID = 3'd7
  } func_e;

  // Classes that produce a GPR result in WB.
  function automatic logic writes_rd(input func_e f);
    return (f == F_ADDI) || (f == F_JALR) || (f == F_AUIPC) ||
           (f == F_LUI)  || (f == F_JAL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22050039_Cnt.sv
// ============================================================================
// ysyx_22050039_Cnt : wrapping up-counter with enable and synchronous clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22050039_Cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear takes priority so a re-entry cycle never carries a stale count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_22050039_ctrl.sv
// ============================================================================
// ysyx_22050039_ctrl : multi-cycle core control FSM (fetch/decode/exec/mem/wb)
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22050039_ctrl
  import ysyx_22050039_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             if_req,
  input  logic             if_ack,
  input  logic [2:0]       func,
  output logic             ex_en,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  output logic             reg_wen,
  output logic             pc_wen,
  output logic             halt,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] inst_cnt
);

  localparam int          TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  func_e         func_q, func_d;
  logic [TW-1:0] tmo_cnt;

  // Counts ack-less FETCH cycles; held at zero outside FETCH so each entry starts fresh.
  ysyx_22050039_Cnt #(.W(TW)) u_tmo_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   ((state_q == S_FETCH) && !if_ack),
    .clr_i  (state_q != S_FETCH),
    .cnt_o  (tmo_cnt)
  );

  ysyx_22050039_Cnt #(.W(CNT_W)) u_inst_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (state_q == S_WB),
    .clr_i  (1'b0),
    .cnt_o  (inst_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      func_q  <= F_ADDI;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
    end
  end

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    if_req  = 1'b0;
    ex_en   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    reg_wen = 1'b0;
    pc_wen  = 1'b0;
    halt    = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if_req = 1'b1;
        // An ack on the expiry cycle still completes the fetch.
        if (if_ack) begin
          state_d = S_DECODE;
          func_d  = func_e'(func);
        end else if (tmo_cnt == TMO_LAST) begin
          state_d = S_ERR;
        end
      end
      S_DECODE: begin
        case (func_q)
          F_EBREAK:  state_d = S_HALT;
          F_INVALID: state_d = S_ERR;
          default:   state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        ex_en   = 1'b1;
        state_d = (func_q == F_SD) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        pc_wen  = 1'b1;
        reg_wen = writes_rd(func_q);
        state_d = S_FETCH;
      end
      S_HALT:  halt = 1'b1;
      S_ERR:   err  = 1'b1;
      default: state_d = S_ERR;
    endcase
  end

  assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050039_ctrl.sv
// ============================================================================
// tb_ysyx_22050039_ctrl : directed self-checking bench for the control FSM
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_22050039_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       if_ack;
  logic [2:0] func;
  logic       mem_ack;
  logic       if_req, ex_en, mem_req, mem_we, reg_wen, pc_wen, halt, err;
  logic [2:0] state;
  logic [3:0] inst_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_22050039_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_ack   (if_ack),
    .func     (func),
    .ex_en    (ex_en),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_ack  (mem_ack),
    .reg_wen  (reg_wen),
    .pc_wen   (pc_wen),
    .halt     (halt),
    .err      (err),
    .state    (state),
    .inst_cnt (inst_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {if_req, ex_en, mem_req, mem_we, reg_wen, pc_wen, halt, err}
  function automatic logic [7:0] outs();
    return {if_req, ex_en, mem_req, mem_we, reg_wen, pc_wen, halt, err};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; if_ack = 1'b0; func = 3'd0; mem_ack = 1'b0;
    tick(); tick();
    chk("reset_state", state, 3'd0);
    chk("reset_outs", outs(), 8'h00);
    chk("reset_cnt", inst_cnt, 4'd0);

    // addi stream: FETCH/DECODE/EXEC/WB repeating
    rst = 1'b1;
    tick();
    chk("first_fetch", {state, outs()}, {3'd1, 8'b1000_0000});
    if_ack = 1'b1; func = 3'd0;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) chk("addi_fetch", {state, outs()}, {3'd1, 8'b1000_0000});
      tick(); chk("addi_decode", {state, outs()}, {3'd2, 8'b0000_0000});
      tick(); chk("addi_exec",   {state, outs()}, {3'd3, 8'b0100_0000});
      tick(); chk("addi_wb",     {state, outs()}, {3'd5, 8'b0000_1100});
      tick();
    end
    chk("addi_cnt3", inst_cnt, 4'd3);

    // sd with mem_ack delayed three cycles
    func = 3'd4;
    tick(); chk("sd_decode", state, 3'd2);
    if_ack = 1'b0;
    tick(); chk("sd_exec", {state, ex_en}, {3'd3, 1'b1});
    for (int i = 0; i < 4; i++) begin
      tick(); chk("sd_mem", {state, outs()}, {3'd4, 8'b0011_0000});
      if (i == 3) mem_ack = 1'b1;
    end
    tick(); chk("sd_wb", {state, outs()}, {3'd5, 8'b0000_0100});
    mem_ack = 1'b0;
    tick(); chk("sd_cnt4", {state, inst_cnt}, {3'd1, 4'd4});

    // ack on the 4th FETCH cycle beats the timeout
    tick(); chk("tmo_wait2", state, 3'd1);
    tick(); chk("tmo_wait3", state, 3'd1);
    tick(); chk("tmo_wait4", state, 3'd1);
    if_ack = 1'b1; func = 3'd5;
    tick(); chk("tmo_ack_wins", {state, err}, {3'd2, 1'b0});
    tick(); tick(); chk("jal_wb", {state, reg_wen, pc_wen}, {3'd5, 2'b11});
    if_ack = 1'b0;
    tick(); chk("jal_cnt5", {state, inst_cnt}, {3'd1, 4'd5});

    // no ack: ERR after 4 FETCH cycles, absorbing
    tick(); tick(); tick();
    chk("tmo_still_fetch", state, 3'd1);
    tick(); chk("tmo_err", {state, outs()}, {3'd7, 8'b0000_0001});
    for (int i = 0; i < 6; i++) begin
      if_ack = ~if_ack;
      tick(); chk("err_sticky", {state, outs()}, {3'd7, 8'b0000_0001});
    end

    // async reset out of ERR
    #2 rst = 1'b0;
    #1 chk("rst_from_err", {state, outs(), inst_cnt}, {3'd0, 8'h00, 4'd0});
    tick(); rst = 1'b1; if_ack = 1'b1; func = 3'd5;

    // 16 jal retire: counter wraps to 0
    for (int i = 0; i <= 16; i++) begin
      tick(); chk("wrap_cnt", {state, err, inst_cnt}, {3'd1, 1'b0, 4'(i)});
      if (i != 16) begin tick(); tick(); tick(); end
    end

    // reset asserted mid-MEM
    func = 3'd4;
    tick(); tick(); tick();
    chk("mem_before_rst", {state, mem_req}, {3'd4, 1'b1});
    #2 rst = 1'b0;
    #1 chk("rst_mid_mem", {state, mem_req, mem_we, inst_cnt}, {3'd0, 2'b00, 4'd0});
    tick(); rst = 1'b1;

    // ebreak halts; if_ack ignored afterwards
    tick(); chk("eb_fetch", state, 3'd1);
    func = 3'd6;
    tick(); chk("eb_decode", {state, halt}, {3'd2, 1'b0});
    for (int i = 0; i < 100; i++) begin
      if_ack = (i % 2 == 0);
      tick(); chk("eb_halt", {state, outs()}, {3'd6, 8'b0000_0010});
    end

    // invalid class traps in ERR
    #2 rst = 1'b0;
    tick(); rst = 1'b1; func = 3'd7; if_ack = 1'b1;
    tick(); chk("inv_fetch", state, 3'd1);
    tick(); chk("inv_decode", state, 3'd2);
    tick(); chk("inv_err", {state, outs()}, {3'd7, 8'b0000_0001});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
